// File: rtl/gpio_bus_ctrl_pkg.sv
// rtl/gpio_bus_ctrl_pkg.sv - shared types and constants for the GPIO bus controller
package gpio_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TURN_OUT = 3'd1,
    ST_STROBE   = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_SETTLE   = 3'd4
  } state_e;

  localparam int REQ_CPU    = 0;
  localparam int REQ_MOTION = 1;
  localparam int N_REQ      = 2;
  localparam int DATA_W     = 32;

  localparam int DEF_TURN_CYCLES   = 2;
  localparam int DEF_STB_CYCLES    = 2;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_CNT_W         = 8;

  // A programmed length of zero still yields a one-cycle phase.
  function automatic int eff_cycles(input int n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/gpio_bus_ctrl_if.sv
// rtl/gpio_bus_ctrl_if.sv - requester handshake and gpio_buf-side signals of the controller
interface gpio_bus_ctrl_if;
  import gpio_ctrl_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    gpio_oe;
  logic [DATA_W-1:0]       gpio_in;
  logic [DATA_W-1:0]       gpio_out;
  logic                    gpio_stb;
  logic                    busy;

  modport master (
    output req_valid, req_we, req_data, gpio_out,
    input  req_ready, rsp_valid, rsp_data, gpio_oe, gpio_in, gpio_stb, busy
  );

  modport slave (
    input  req_valid, req_we, req_data, gpio_out,
    output req_ready, rsp_valid, rsp_data, gpio_oe, gpio_in, gpio_stb, busy
  );

endinterface

// File: rtl/gpio_bus_ctrl_rr_arb2.sv
// rtl/gpio_bus_ctrl_rr_arb2.sv - two-way round-robin arbiter, pointer moves to the loser on accept
module gpio_rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gpio_bus_ctrl.sv
// rtl/gpio_bus_ctrl.sv - sequences the shared GPIO bus between two requesters
// Optional GPIO_CTRL_KEEP_DIR_EN keeps the bus driven across consecutive writes.
module gpio_bus_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int TURN_CYCLES   = DEF_TURN_CYCLES,
  parameter int STB_CYCLES    = DEF_STB_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  gpio_bus_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(eff_cycles(TURN_CYCLES) - 1);
  localparam logic [CNT_W-1:0] STB_LD    = CNT_W'(eff_cycles(STB_CYCLES) - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(eff_cycles(SETTLE_CYCLES) - 1);

`ifdef GPIO_CTRL_KEEP_DIR_EN
  localparam bit KEEP_DIR = 1'b1;
`else
  localparam bit KEEP_DIR = 1'b0;
`endif

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q;
  logic [DATA_W-1:0] gin_q;
  logic              oe_q;
  logic              stb_q;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              cnt_zero;
  logic              accept_win;
  logic [N_REQ-1:0]  arb_valid;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  ready;
  logic              accept;
  logic              acc_idx;
  logic              acc_we;
  logic [DATA_W-1:0] acc_data;

  assign cnt_zero = (cnt_q == '0);

  // Outside IDLE only the last strobe cycle may accept, and only a write.
  assign accept_win = (state_q == ST_IDLE) ||
                      (KEEP_DIR && (state_q == ST_STROBE) && cnt_zero);
  assign arb_valid  = (state_q == ST_IDLE) ? bus.req_valid
                                           : (bus.req_valid & bus.req_we);

  gpio_rr_arb2 u_arb (
    .clk_i    (clk),
    .reset_i  (reset),
    .valid_i  (arb_valid),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign ready    = grant & {N_REQ{accept_win}};
  assign accept   = |ready;
  assign acc_idx  = ready[REQ_MOTION];
  assign acc_we   = acc_idx ? bus.req_we[REQ_MOTION] : bus.req_we[REQ_CPU];
  assign acc_data = acc_idx ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      gin_q       <= '0;
      oe_q        <= 1'b0;
      stb_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= acc_idx;
            if (acc_we) begin
              gin_q   <= acc_data;
              oe_q    <= 1'b1;
              state_q <= ST_TURN_OUT;
              cnt_q   <= TURN_LD;
            end else begin
              state_q <= ST_SETTLE;
              cnt_q   <= SETTLE_LD;
            end
          end
        end
        ST_TURN_OUT: begin
          if (cnt_zero) begin
            state_q <= ST_STROBE;
            cnt_q   <= STB_LD;
            stb_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt_zero) begin
            stb_q <= 1'b0;
            if (KEEP_DIR) begin
              rsp_valid_q[owner_q] <= 1'b1;
              rsp_data_q           <= '0;
            end
            if (accept) begin
              // Bus stays driven; one strobe-low cycle presents the new data first.
              owner_q <= acc_idx;
              gin_q   <= acc_data;
              state_q <= ST_TURN_OUT;
              cnt_q   <= '0;
            end else begin
              oe_q    <= 1'b0;
              state_q <= ST_RELEASE;
              cnt_q   <= TURN_LD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_zero) begin
            state_q <= ST_IDLE;
            if (!KEEP_DIR) begin
              rsp_valid_q[owner_q] <= 1'b1;
              rsp_data_q           <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state_q              <= ST_IDLE;
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_data_q           <= bus.gpio_out;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.gpio_oe   = oe_q;
  assign bus.gpio_in   = gin_q;
  assign bus.gpio_stb  = stb_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_bus_ctrl.sv
// tb/tb_gpio_bus_ctrl.sv - scoreboard bench for gpio_bus_ctrl with a transaction-level reference model
module tb_gpio_bus_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int TURN   = 2;
  localparam int STB    = 2;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic reset;
  gpio_bus_ctrl_if bus ();

  gpio_bus_ctrl #(
    .TURN_CYCLES   (TURN),
    .STB_CYCLES    (STB),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int owner;
    bit we;
    int t;
    int due;
  } exp_t;

  exp_t sb[$];
  logic [31:0] pin_hist[int];
  int n_cmp = 0;
  int n_bad = 0;
  int free_at = 0;
  int ptr_m = 0;
  bit cur_we = 1'b0;
  int cur_t = -100;
  logic [31:0] gin_m = '0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
    end
  endtask

  // Drive one cycle of requests; the model decides who must be granted.
  task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [63:0] d,
                      input logic [31:0] pin);
    logic [1:0] exp_rdy;
    int g;
    int tt;
    bit w;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_data  = d;
    bus.gpio_out  = pin;
    pin_hist[edge_n] = pin;
    #1;
    exp_rdy = 2'b00;
    if (edge_n >= free_at) begin
      if (v == 2'b11) exp_rdy = (ptr_m == 1) ? 2'b10 : 2'b01;
      else            exp_rdy = v;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      g     = exp_rdy[1] ? 1 : 0;
      tt    = edge_n + 1;
      w     = we[g];
      ptr_m = 1 - g;
      sb.push_back('{owner: g, we: w, t: tt, due: tt + (w ? 2*TURN + STB : SETTLE)});
      free_at = tt + (w ? 2*TURN + STB : SETTLE);
      cur_we  = w;
      cur_t   = tt;
      if (w) gin_m = d[g*32 +: 32];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 2'b00;
    pin_hist[edge_n] = bus.gpio_out;
    #1;
    sb.delete();
    free_at = edge_n + 1;
    ptr_m   = 0;
    cur_we  = 1'b0;
    cur_t   = -100;
    gin_m   = '0;
    @(negedge clk);
    pin_hist[edge_n] = bus.gpio_out;
    chk("rst_gpio_oe",    32'(bus.gpio_oe),   32'd0);
    chk("rst_gpio_stb",   32'(bus.gpio_stb),  32'd0);
    chk("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    chk("rst_busy",       32'(bus.busy),      32'd0);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    bit exp_oe;
    bit exp_stb;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_oe  = cur_we && (edge_n >= cur_t) && (edge_n <= cur_t + TURN + STB - 1);
        exp_stb = cur_we && (edge_n >= cur_t + TURN) && (edge_n <= cur_t + TURN + STB - 1);
        chk("gpio_oe",  32'(bus.gpio_oe),  32'(exp_oe));
        chk("gpio_stb", 32'(bus.gpio_stb), 32'(exp_stb));
        chk("gpio_in",  bus.gpio_in,       gin_m);
        chk("busy",     32'(bus.busy),     32'(edge_n < free_at));
        if (bus.rsp_valid != 2'b00) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_owner", 32'(bus.rsp_valid), 32'(1 << e.owner));
            chk("rsp_time",  32'(edge_n),        32'(e.due));
            if (e.we) chk("rsp_data_wr", bus.rsp_data, 32'd0);
            else      chk("rsp_data_rd", bus.rsp_data, pin_hist[e.t + SETTLE - 1]);
          end
        end else if (sb.size() > 0 && sb[0].due < edge_n) begin
          chk("rsp_timeout", 32'(edge_n), 32'(sb[0].due));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : driver
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_data  = '0;
    bus.gpio_out  = '0;
    repeat (3) @(negedge clk);
    chk("init_gpio_oe",    32'(bus.gpio_oe),   32'd0);
    chk("init_gpio_stb",   32'(bus.gpio_stb),  32'd0);
    chk("init_gpio_in",    bus.gpio_in,        32'd0);
    chk("init_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    chk("init_rsp_data",   bus.rsp_data,       32'd0);
    chk("init_busy",       32'(bus.busy),      32'd0);
    chk("init_req_ready",  32'(bus.req_ready), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    step(2'b01, 2'b01, {32'h0, 32'hDEADBEEF}, 32'h0);
    repeat (8) step(2'b00, 2'b00, '0, 32'h0);

    step(2'b10, 2'b00, '0, 32'h12345678);
    repeat (4) step(2'b00, 2'b00, '0, 32'h12345678);

    for (int i = 0; i < 40; i++)
      step(2'b11, 2'($urandom), {$urandom, $urandom}, $urandom);
    repeat (8) step(2'b00, 2'b00, '0, $urandom);

    for (int i = 0; i < 12; i++)
      step(2'b11, 2'b01, {$urandom, $urandom}, $urandom);
    repeat (8) step(2'b00, 2'b00, '0, $urandom);

    step(2'b11, 2'b11, {32'hA5A5A5A5, 32'h0F0F0F0F}, 32'h0);
    while (edge_n < cur_t + TURN) step(2'b00, 2'b00, '0, 32'h0);
    do_reset();
    step(2'b11, 2'b00, '0, 32'hCAFEF00D);
    repeat (4) step(2'b00, 2'b00, '0, 32'hCAFEF00D);

    for (int i = 0; i < 1500; i++)
      step(2'($urandom), 2'($urandom), {$urandom, $urandom}, $urandom);

    repeat (12) step(2'b00, 2'b00, '0, 32'h0);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
